// File: rtl/mult_seq_ctrl.sv
// Sequencer for the signed shift-add multiplier: TEST / ADD-or-SUB / SHIFT per multiplier bit, then HOLD.
// Latency: HOLD is entered 2 + 2*WIDTH + ones(B) cycles after Run is sampled; Moore outputs except Clr_Ld.
// Backpressure: Run is a level; HOLD waits for Run to drop, so one multiply per Run high period.
module mult_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Run,
  input  logic          ClearA_LoadB,
  input  logic          M,
  output logic          Clr_Ld,
  output logic          Clear_AX,
  output logic          Add,
  output logic          Sub,
  output logic          Shift_En,
  output logic          Busy,
  output logic          Done,
  output logic [CW-1:0] Bit_Cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_TEST,
    S_ADD,
    S_SUB,
    S_SHIFT,
    S_HOLD
  } state_t;

  // Index of the multiplier's sign bit; that bit is subtracted instead of added.
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] bit_cnt;
  logic [CW-1:0] bit_cnt_nxt;
  logic          is_last;

  assign is_last = (bit_cnt == LAST_BIT);
  assign Bit_Cnt = bit_cnt;

  // State and bit-counter registers; reset aborts any multiply in progress.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
    end
  end

  // Next-state and bit-counter update.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    case (state)
      S_IDLE: begin
        if (Run) state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        bit_cnt_nxt = '0;
        state_nxt   = S_TEST;
      end
      S_TEST: begin
        if (!M)          state_nxt = S_SHIFT;
        else if (is_last) state_nxt = S_SUB;
        else             state_nxt = S_ADD;
      end
      S_ADD:   state_nxt = S_SHIFT;
      S_SUB:   state_nxt = S_SHIFT;
      S_SHIFT: begin
        if (is_last) begin
          bit_cnt_nxt = '0;
          state_nxt   = S_HOLD;
        end else begin
          bit_cnt_nxt = bit_cnt + 1'b1;
          state_nxt   = S_TEST;
        end
      end
      S_HOLD: begin
        if (!Run) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt   = S_IDLE;
        bit_cnt_nxt = '0;
      end
    endcase
  end

  // Output decode; only Clr_Ld looks at inputs, and Run overrides the load request.
  always_comb begin
    Clr_Ld   = 1'b0;
    Clear_AX = 1'b0;
    Add      = 1'b0;
    Sub      = 1'b0;
    Shift_En = 1'b0;
    Busy     = 1'b0;
    Done     = 1'b0;
    case (state)
      S_IDLE:  Clr_Ld = ClearA_LoadB & ~Run;
      S_CLEAR: begin
        Clear_AX = 1'b1;
        Busy     = 1'b1;
      end
      S_TEST:  Busy = 1'b1;
      S_ADD: begin
        Add  = 1'b1;
        Busy = 1'b1;
      end
      S_SUB: begin
        Sub  = 1'b1;
        Busy = 1'b1;
      end
      S_SHIFT: begin
        Shift_En = 1'b1;
        Busy     = 1'b1;
      end
      S_HOLD:  Done = 1'b1;
      default: ;
    endcase
  end

endmodule
